// File: rtl/priority_grant_arbiter_pkg.sv
// Shared types and elaboration checks for the registered priority/round-robin grant arbiter.
package priority_grant_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Widest grant index the width check can evaluate without overflowing a 32-bit shift.
  localparam int IDX_W_MAX = 30;

  function automatic bit lines_fit(input int lines, input int out_width);
    return (out_width >= 1) && (out_width <= IDX_W_MAX) &&
           (lines >= 1) && (lines <= (1 << out_width));
  endfunction

endpackage

// File: rtl/priority_grant_arbiter_if.sv
// Request/mask/grant bundle between event sources, the arbiter and the dispatch consumer.
interface priority_grant_arbiter_if #(
  parameter int OUT_WIDTH = 3,
  parameter int LINES     = 1 << OUT_WIDTH
);
  logic [LINES-1:0]     req;
  logic [LINES-1:0]     mask;
  logic                 clear_all;
  logic                 grant_valid;
  logic                 grant_ready;
  logic [OUT_WIDTH-1:0] grant_index;
  logic [LINES-1:0]     grant_onehot;
  logic [LINES-1:0]     pending;
  logic                 any_pending;

  modport master (
    output req, mask, clear_all, grant_ready,
    input  grant_valid, grant_index, grant_onehot, pending, any_pending
  );

  modport slave (
    input  req, mask, clear_all, grant_ready,
    output grant_valid, grant_index, grant_onehot, pending, any_pending
  );
endinterface

// File: rtl/priority_grant_arbiter_masked_priority_select.sv
// Combinational highest-index-first selector: reports whether any bit is set and the top set index.
module masked_priority_select #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             found_o,
  output logic [IDX_W-1:0] index_o
);

  // Ascending scan so the last hit, i.e. the highest index, wins.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) begin
        found_o = 1'b1;
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_grant_arbiter.sv
// Latches request events into pending bits and offers one masked line at a time on a valid/ready port,
// by fixed priority (highest index) or round-robin below the last granted index; one bubble between grants.
module priority_grant_arbiter
  import priority_grant_arbiter_pkg::*;
#(
  parameter int OUT_WIDTH   = 3,
  parameter int LINES       = 1 << OUT_WIDTH,
  parameter int ROUND_ROBIN = 0
) (
  input logic                     clk,
  input logic                     reset,
  priority_grant_arbiter_if.slave bus
);

  localparam bit LINES_OK = lines_fit(LINES, OUT_WIDTH);

  if (!LINES_OK) begin : g_bad_width
    $fatal(1, "priority_grant_arbiter: LINES must be in 1 .. 1 << OUT_WIDTH");
  end

  state_e               state_q, state_d;
  logic [LINES-1:0]     pending_q, pending_d;
  logic [LINES-1:0]     onehot_q, onehot_d;
  logic [OUT_WIDTH-1:0] idx_q, idx_d;
  logic [OUT_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                 valid_q, valid_d;

  logic [LINES-1:0]     cand, below_ptr;
  logic                 lo_found, all_found, accept;
  logic [OUT_WIDTH-1:0] lo_idx, all_idx, sel_idx;

  assign accept = valid_q & bus.grant_ready;
  assign cand   = pending_q & bus.mask;

  always_comb begin
    for (int i = 0; i < LINES; i++) begin
      below_ptr[i] = (i < int'(rr_ptr_q));
    end
  end

  masked_priority_select #(.WIDTH(LINES), .IDX_W(OUT_WIDTH)) u_sel_below (
    .vec_i   (cand & below_ptr),
    .found_o (lo_found),
    .index_o (lo_idx)
  );

  masked_priority_select #(.WIDTH(LINES), .IDX_W(OUT_WIDTH)) u_sel_all (
    .vec_i   (cand),
    .found_o (all_found),
    .index_o (all_idx)
  );

  // Round-robin falls back to the unrestricted search when nothing sits below the pointer.
  assign sel_idx = ((ROUND_ROBIN != 0) && lo_found) ? lo_idx : all_idx;

  always_comb begin
    pending_d = bus.req | (pending_q & ~(accept ? onehot_q : '0));
    state_d   = state_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    rr_ptr_d  = rr_ptr_q;
    if (bus.clear_all) begin
      pending_d = '0;
      state_d   = IDLE;
      valid_d   = 1'b0;
      onehot_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (all_found) begin
            state_d  = OFFER;
            valid_d  = 1'b1;
            idx_d    = sel_idx;
            onehot_d = LINES'(1) << sel_idx;
          end
        end
        OFFER: begin
          if (accept) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            onehot_d = '0;
            rr_ptr_d = idx_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      onehot_q  <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.grant_valid  = valid_q;
  assign bus.grant_index  = idx_q;
  assign bus.grant_onehot = onehot_q;
  assign bus.pending      = pending_q;
  assign bus.any_pending  = |pending_q;

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter side by side against a behavioural model and directed expectations.
module tb_priority_grant_arbiter;
  localparam int OW = 3;
  localparam int L  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [L-1:0] req_v [2];
  logic [L-1:0] mask_v;
  logic         clr_v, rdy_v;

  priority_grant_arbiter_if #(.OUT_WIDTH(OW), .LINES(L)) bus0 ();
  priority_grant_arbiter_if #(.OUT_WIDTH(OW), .LINES(L)) bus1 ();

  assign bus0.req = req_v[0];
  assign bus1.req = req_v[1];
  assign bus0.mask = mask_v;
  assign bus1.mask = mask_v;
  assign bus0.clear_all = clr_v;
  assign bus1.clear_all = clr_v;
  assign bus0.grant_ready = rdy_v;
  assign bus1.grant_ready = rdy_v;

  priority_grant_arbiter #(.OUT_WIDTH(OW), .LINES(L), .ROUND_ROBIN(0)) u_fix (
    .clk(clk), .reset(reset), .bus(bus0));
  priority_grant_arbiter #(.OUT_WIDTH(OW), .LINES(L), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset), .bus(bus1));

  logic         gv [2];
  logic [OW-1:0] gi [2];
  logic [L-1:0] goh [2];
  logic [L-1:0] gp [2];
  logic         gap [2];
  assign gv[0] = bus0.grant_valid;   assign gv[1] = bus1.grant_valid;
  assign gi[0] = bus0.grant_index;   assign gi[1] = bus1.grant_index;
  assign goh[0] = bus0.grant_onehot; assign goh[1] = bus1.grant_onehot;
  assign gp[0] = bus0.pending;       assign gp[1] = bus1.pending;
  assign gap[0] = bus0.any_pending;  assign gap[1] = bus1.any_pending;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut %0d rr=%0d): got %0h, expected %0h", name, m, m, act, exp);
  endtask

  // Behavioural model: dut 0 fixed priority, dut 1 round-robin.
  bit [L-1:0] m_pend [2];
  bit         m_offer [2];
  int         m_idx [2];
  int         m_ptr [2];
  int         dq [2][$];
  int         mq [2][$];

  // Scan downward from start-1 with wraparound; start 0 means plain highest-index-first.
  function automatic int pick(input bit [L-1:0] cand, input int start);
    for (int k = 1; k <= L; k++) begin
      int j;
      j = ((start - k) % L + L) % L;
      if (cand[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit [L-1:0] r;
    int p;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = '0; m_offer[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        r = req_v[m];
        if (clr_v) begin
          m_pend[m] = '0;
          m_offer[m] = 1'b0;
        end else if (m_offer[m]) begin
          if (rdy_v) begin
            m_pend[m][m_idx[m]] = 1'b0;
            mq[m].push_back(m_idx[m]);
            m_ptr[m] = m_idx[m];
            m_offer[m] = 1'b0;
          end
          m_pend[m] = m_pend[m] | r;
        end else begin
          p = pick(m_pend[m] & mask_v, (m == 1) ? m_ptr[m] : 0);
          if (p >= 0) begin
            m_offer[m] = 1'b1;
            m_idx[m] = p;
          end
          m_pend[m] = m_pend[m] | r;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk("grant_valid", m, gv[m], m_offer[m]);
      if (m_offer[m]) chk("grant_index", m, gi[m], m_idx[m]);
      chk("grant_onehot", m, goh[m], m_offer[m] ? (32'd1 << m_idx[m]) : 32'd0);
      chk("pending", m, gp[m], m_pend[m]);
      chk("any_pending", m, gap[m], |m_pend[m]);
      if (gv[m] && rdy_v) dq[m].push_back(gi[m]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_seq();
    for (int m = 0; m < 2; m++) begin
      dq[m].delete();
      mq[m].delete();
    end
  endtask

  task automatic chk_seq(input string name, input int m, input int exp [4], input int n, input bit exact);
    if (exact) begin
      chk({name, "_count"}, m, dq[m].size(), n);
      chk({name, "_model_count"}, m, mq[m].size(), n);
    end else begin
      chk({name, "_enough"}, m, dq[m].size() >= n, 1);
      chk({name, "_model_enough"}, m, mq[m].size() >= n, 1);
    end
    for (int k = 0; k < n; k++) begin
      if (k < dq[m].size()) chk(name, m, dq[m][k], exp[k]);
      if (k < mq[m].size()) chk({name, "_model"}, m, mq[m][k], exp[k]);
    end
  endtask

  task automatic set_req(input logic [L-1:0] v);
    req_v[0] = v;
    req_v[1] = v;
  endtask

  initial begin
    set_req('0);
    mask_v = '1; clr_v = 1'b0; rdy_v = 1'b0;
    #12 reset = 1'b0;
    tick(1);
    for (int m = 0; m < 2; m++) begin
      chk("rst_valid", m, gv[m], 0);
      chk("rst_pending", m, gp[m], 0);
    end

    // Three lines in one burst, always ready.
    clear_seq();
    rdy_v = 1'b1;
    set_req(8'b0010_0101); tick(1); set_req('0); tick(10);
    for (int m = 0; m < 2; m++) begin
      chk_seq("burst_seq", m, '{5, 2, 0, 0}, 3, 1'b1);
      chk("burst_drained", m, gp[m], 0);
    end

    // Re-raise the granted line during each accept: round-robin alternates, fixed starves line 1.
    clear_seq();
    set_req(8'h42); tick(1);
    repeat (12) begin
      req_v[0] = goh[0];
      req_v[1] = goh[1];
      tick(1);
    end
    set_req('0); tick(10);
    chk_seq("fixed_starve", 0, '{6, 6, 6, 0}, 3, 1'b0);
    chk_seq("rr_alternate", 1, '{6, 1, 6, 1}, 4, 1'b0);

    // Backpressure holds the offer while a higher line arrives.
    clear_seq();
    rdy_v = 1'b0;
    set_req(8'h04); tick(1); set_req('0); tick(1);
    for (int k = 0; k < 5; k++) begin
      set_req((k % 2 == 0) ? 8'h80 : 8'h00);
      tick(1);
    end
    for (int m = 0; m < 2; m++) begin
      chk("stall_valid", m, gv[m], 1);
      chk("stall_index", m, gi[m], 2);
    end
    set_req('0); rdy_v = 1'b1; tick(6);
    for (int m = 0; m < 2; m++) chk_seq("stall_seq", m, '{2, 7, 0, 0}, 2, 1'b1);

    // A masked line waits until unmasked.
    rdy_v = 1'b0; mask_v = 8'hF7;
    set_req(8'h08); tick(1); set_req('0); tick(3);
    for (int m = 0; m < 2; m++) begin
      chk("masked_valid", m, gv[m], 0);
      chk("masked_any", m, gap[m], 1);
    end
    mask_v = 8'hFF; tick(1);
    for (int m = 0; m < 2; m++) begin
      chk("unmask_valid", m, gv[m], 1);
      chk("unmask_index", m, gi[m], 3);
    end
    rdy_v = 1'b1; tick(2);

    // clear_all withdraws an offer and beats a simultaneous request.
    rdy_v = 1'b0;
    set_req(8'h20); tick(1); set_req('0); tick(1);
    for (int m = 0; m < 2; m++) chk("pre_clear_index", m, gi[m], 5);
    clr_v = 1'b1; set_req(8'h02); tick(1); clr_v = 1'b0; set_req('0);
    for (int m = 0; m < 2; m++) begin
      chk("clear_pending", m, gp[m], 0);
      chk("clear_valid", m, gv[m], 0);
    end
    tick(3);
    for (int m = 0; m < 2; m++) chk("clear_quiet", m, gv[m], 0);

    // A request on the line being accepted survives the accept.
    rdy_v = 1'b1;
    set_req(8'h01); tick(1); set_req('0); tick(1);
    set_req(8'h01); tick(1); set_req('0);
    for (int m = 0; m < 2; m++) begin
      chk("reraise_pending", m, gp[m], 8'h01);
      chk("reraise_bubble", m, gv[m], 0);
    end
    tick(1);
    for (int m = 0; m < 2; m++) chk("reraise_index", m, gi[m], 0);
    tick(3);

    // Asynchronous reset in the middle of an offer.
    rdy_v = 1'b0;
    set_req(8'h10); tick(1); set_req('0); tick(1);
    for (int m = 0; m < 2; m++) chk("pre_reset_index", m, gi[m], 4);
    #3 reset = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async_rst_valid", m, gv[m], 0);
      chk("async_rst_index", m, gi[m], 0);
      chk("async_rst_onehot", m, goh[m], 0);
      chk("async_rst_pending", m, gp[m], 0);
    end
    tick(1);
    #2 reset = 1'b0;
    tick(4);
    for (int m = 0; m < 2; m++) chk("post_rst_idle", m, gv[m], 0);
    set_req(8'h10); tick(1); set_req('0); tick(1);
    for (int m = 0; m < 2; m++) chk("post_rst_index", m, gi[m], 4);
    rdy_v = 1'b1; tick(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/priority_grant_arbiter.md
Name: priority_grant_arbiter

Overview:
Registered successor to the combinational priority encoder. It latches request events into pending bits and applies a per-line enable mask. It picks one line by fixed priority (highest index wins) or by round-robin, and offers it on a valid/ready grant port. It sits between interrupt/event sources and the core's dispatch logic, which accepts one grant at a time.

Parameters:
OUT_WIDTH, 3, width of grant_index.
LINES, 1 << OUT_WIDTH, number of request lines; 1 <= LINES <= (1 << OUT_WIDTH).
ROUND_ROBIN, 0, 0 = fixed priority (highest index wins); 1 = round-robin, searching downward from the last granted index.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous active-high reset.
req  input  LINES  per-line event; a 1 in any cycle sets that line's pending bit.
mask  input  LINES  per-line enable; 1 = eligible for selection.
clear_all  input  1  synchronous flush of pending bits and any outstanding offer.
grant_valid  output  1  an offer is presented.
grant_ready  input  1  consumer accepts the offer when this and grant_valid are both high.
grant_index  output  OUT_WIDTH  index of the offered line.
grant_onehot  output  LINES  one-hot form of grant_index; all zero when grant_valid = 0.
pending  output  LINES  registered pending bits.
any_pending  output  1  OR of pending; mask is ignored.

Behaviour:
- Reset, asynchronous: pending = 0, grant_valid = 0, grant_index = 0, grant_onehot = 0, rr_ptr = 0, state = IDLE.
- Pending update:
  - pending_next[i] = req[i] | (pending[i] & ~(accept & grant_index == i)).
  - When req[i] arrives in the same cycle that grant i is accepted, the pending bit stays 1 (new event, not lost).
- State machine with two states, IDLE and OFFER:
  - IDLE: cand = pending & mask, using registered pending only. If cand != 0, register the selected index and go to OFFER. Otherwise stay in IDLE.
  - OFFER: grant_valid = 1. grant_index is held stable until accept, regardless of changes to mask, req or pending.
  - On accept: clear that pending bit, set rr_ptr = grant_index, and return to IDLE.
- Consequences of the state machine:
  - There is one bubble cycle between consecutive grants.
  - Latency: req at edge n sets pending at n+1, and grant_valid rises at n+2.
- Fixed selection: the highest set index of cand.
- Round-robin selection:
  - First choice is the highest set index of cand among indices strictly below rr_ptr.
  - If there is none, take the highest set index of cand overall, which wraps the search.
  - With rr_ptr = 0 at reset, the first search therefore starts at LINES-1, matching fixed mode.
- clear_all:
  - Next edge: pending = 0, state = IDLE, grant_valid = 0. This is the only case where an offer is withdrawn without accept.
  - clear_all has priority over req and over accept in that cycle; rr_ptr is unchanged.
- Width rule: indices of LINES and above are never produced. When LINES < 1 << OUT_WIDTH, grant_index is zero-extended.
- A masked pending bit stays pending indefinitely. Unmasking it at edge n yields grant_valid at edge n+1 if the block is in IDLE.

Decomposition:
- Shared package holds: the state enum (IDLE, OFFER) and the localparam for the index width check (LINES <= 1 << OUT_WIDTH), enforced by an elaboration-time assertion.
- One combinational sub-module, masked_priority_select, with a LINES-wide vector in and {found, index} out, highest index first.
- Instantiated twice in round-robin mode: once on cand & below_ptr_mask, once on cand. Only the second instance is used in fixed mode.

Test Plan:
- Reset asserted asynchronously mid-OFFER with index 4 -> all outputs 0 immediately; no grant after release until a new req.
- Fixed mode, mask = all 1s, req = 8'b0010_0101 for one cycle, grant_ready = 1 -> grants 5, 2, 0 on alternating cycles; pending ends at 0.
- Round-robin mode, req[6] and req[1] pulsed again after each of their grants, ready = 1 -> grant sequence 6, 1, 6, 1. The same stimulus in fixed mode -> 6, 6, 6.
- Backpressure: offer index 2 with grant_ready = 0 for 5 cycles while req[7] pulses -> index stays 2 and grant_valid stays 1; after accept, the next grant is 7.
- Mask: pending[3] = 1 with mask[3] = 0 -> grant_valid = 0 and any_pending = 1; set mask[3] = 1 -> grant_index = 3 one cycle later.
- clear_all during an OFFER of index 5, with req[1] in the same cycle -> next cycle pending = 0 and grant_valid = 0. Simultaneously, accept of index 0 while req[0] is high -> pending[0] remains 1.
